// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: issues one data-memory bus transaction per M instruction,
// stalls the pipeline until it completes and returns extracted/extended load data.
module mem_access_unit #(
  parameter logic [31:0] DM_BASE = 32'h0000_0000,
  parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [1:0]  m_size,
  input  logic        m_signed,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_hold,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_signed;
  logic [1:0]  r_size, r_lane;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_be;

  logic        w_acc, w_mis, w_oor, w_err, w_start, w_cap;
  logic [32:0] w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wd;

  function automatic logic [31:0] f_extract(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {a, 3'b000});
    h = a[1] ? d[31:16] : d[15:0];
    if (sz == 2'b00)      return {{24{sg & b[7]}}, b};
    else if (sz == 2'b01) return {{16{sg & h[15]}}, h};
    else                  return d;
  endfunction

  // 33-bit offset so an address below DM_BASE shows up as a borrow
  assign w_off   = {1'b0, m_addr} - {1'b0, DM_BASE};
  assign w_oor   = w_off[32] | (w_off[31:0] >= DM_SIZE);
  assign w_mis   = (m_size[1] & (|m_addr[1:0])) | ((m_size == 2'b01) & m_addr[0]);
  assign w_acc   = (r_state == S_IDLE) & m_valid & (m_load | m_store);
  assign w_err   = w_acc & (w_mis | w_oor);
  assign w_start = w_acc & ~w_mis & ~w_oor;
  assign adel    = w_err & m_load;
  assign ades    = w_err & m_store;

  always_comb begin
    w_be = 4'b1111;
    w_wd = m_wdata;
    case (m_size)
      2'b00: begin
        w_be = 4'b0001 << m_addr[1:0];
        w_wd = {4{m_wdata[7:0]}};
      end
      2'b01: begin
        w_be = m_addr[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{m_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // ready+rvalid together in REQ is a legal fast path straight to DONE
  assign w_cap = ~r_we & (((r_state == S_REQ) & bus_ready & bus_rvalid) |
                          ((r_state == S_WAIT_R) & bus_rvalid));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next = S_REQ;
      S_REQ:    if (bus_ready) w_next = (r_we | bus_rvalid) ? S_DONE : S_WAIT_R;
      S_WAIT_R: if (bus_rvalid) w_next = S_DONE;
      S_DONE:   if (!m_hold) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= 2'b00;
      r_lane   <= 2'b00;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_be     <= 4'h0;
      r_ld     <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_we     <= m_store;
        r_signed <= m_signed;
        r_size   <= m_size;
        r_lane   <= m_addr[1:0];
        r_addr   <= {m_addr[31:2], 2'b00};
        r_be     <= m_store ? w_be : 4'b1111;
        r_wdata  <= m_store ? w_wd : 32'h0;
      end
      if (w_cap) r_ld <= f_extract(bus_rdata, r_size, r_signed, r_lane);
    end
  end

  assign bus_req   = (r_state == S_REQ);
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign stall     = w_start | (r_state == S_REQ) | (r_state == S_WAIT_R);
  assign ld_valid  = (r_state == S_DONE) & ~r_we;
  assign ld_data   = r_ld;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected bus requests and load
// results into queues; a monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;

  logic        clk, reset;
  logic        m_valid, m_load, m_store, m_signed, m_hold;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        bus_req, bus_we, bus_ready, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        stall, ld_valid, adel, ades;
  logic [31:0] ld_data;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_load(m_load), .m_store(m_store), .m_size(m_size),
    .m_signed(m_signed), .m_addr(m_addr), .m_wdata(m_wdata), .m_hold(m_hold),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .adel(adel), .ades(ades)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  req_t        exp_q[$];
  logic [31:0] ld_q[$];
  int          errors = 0;
  int          checks = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: pops expectations on each accepted request and each new load result
  initial begin
    logic prev_lv;
    req_t r;
    prev_lv = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (bus_req && bus_ready) begin
        if (exp_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else begin
          r = exp_q.pop_front();
          chk("req_we", {31'b0, bus_we}, {31'b0, r.we});
          chk("req_addr", bus_addr, r.addr);
          chk("req_be", {28'b0, bus_be}, {28'b0, r.be});
          if (r.we) chk("req_wdata", bus_wdata, r.wd);
        end
      end
      if (ld_valid && !prev_lv) begin
        if (ld_q.size() == 0) chk("unexpected_ld", 32'd1, 32'd0);
        else chk("ld_data", ld_data, ld_q.pop_front());
      end
      prev_lv = ld_valid;
    end
  end

  task automatic idle_inputs();
    m_valid = 0; m_load = 0; m_store = 0; m_size = 0; m_signed = 0;
    m_addr = 0; m_wdata = 0; m_hold = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
  endtask

  task automatic access(input string nm, input logic ld, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int rd, input int rv,
                        input logic [31:0] rdata, input int hold, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic [31:0] exp_ld);
    int req_cyc, stall_cyc, rv_cnt, held;
    bit stable, finished;
    logic [31:0] a0, w0;
    logic [3:0]  b0;
    req_t r;
    req_cyc = 0; stall_cyc = 0; rv_cnt = -1; held = 0; stable = 1; finished = 0;
    a0 = 0; w0 = 0; b0 = 0;
    r.we = ~ld; r.addr = {addr[31:2], 2'b00}; r.be = exp_be; r.wd = exp_wd;
    exp_q.push_back(r);
    if (ld) ld_q.push_back(exp_ld);
    @(negedge clk);
    m_valid = 1; m_load = ld; m_store = ~ld; m_size = sz; m_signed = sg;
    m_addr = addr; m_wdata = wd;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      m_hold = (held < hold);
      bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
      #1;
      if (bus_req) begin
        if (req_cyc == 0) begin a0 = bus_addr; b0 = bus_be; w0 = bus_wdata; end
        else if (bus_addr !== a0 || bus_be !== b0 || bus_wdata !== w0) stable = 0;
        if (req_cyc == rd) begin
          bus_ready = 1;
          rv_cnt = 0;
          if (ld && rv == 0) begin bus_rvalid = 1; bus_rdata = rdata; end
        end
        req_cyc++;
      end else if (rv_cnt >= 0) begin
        rv_cnt++;
        if (ld && rv_cnt == rv) begin bus_rvalid = 1; bus_rdata = rdata; end
      end
      #1;
      if (stall) stall_cyc++;
      else begin
        chk({nm, "_ld_valid"}, {31'b0, ld_valid}, {31'b0, ld});
        if (ld) chk({nm, "_ld_hold"}, ld_data, exp_ld);
        if (!m_hold) begin
          @(posedge clk);
          finished = 1;
          break;
        end
        held++;
      end
      @(posedge clk);
    end
    if (!finished) chk({nm, "_timeout"}, 32'd1, 32'd0);
    @(negedge clk);
    idle_inputs();
    chk({nm, "_stall_cycles"}, stall_cyc, 1 + rd + 1 + (ld ? rv : 0));
    chk({nm, "_req_cycles"}, req_cyc, rd + 1);
    chk({nm, "_bus_stable"}, {31'b0, stable}, 32'd1);
    chk({nm, "_hold_cycles"}, held, hold);
  endtask

  task automatic err_access(input string nm, input logic ld, input logic [1:0] sz,
                            input logic [31:0] addr);
    @(negedge clk);
    m_valid = 1; m_load = ld; m_store = ~ld; m_size = sz; m_addr = addr; m_wdata = 32'hFFFF_FFFF;
    #2;
    chk({nm, "_adel"}, {31'b0, adel}, {31'b0, ld});
    chk({nm, "_ades"}, {31'b0, ades}, {31'b0, ~ld});
    chk({nm, "_req"}, {31'b0, bus_req}, 32'd0);
    chk({nm, "_stall"}, {31'b0, stall}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #2;
    chk({nm, "_no_req_after"}, {31'b0, bus_req | stall}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req"}, {31'b0, bus_req}, 32'd0);
    chk({nm, "_we"}, {31'b0, bus_we}, 32'd0);
    chk({nm, "_addr"}, bus_addr, 32'd0);
    chk({nm, "_be"}, {28'b0, bus_be}, 32'd0);
    chk({nm, "_wdata"}, bus_wdata, 32'd0);
    chk({nm, "_ld_data"}, ld_data, 32'd0);
    chk({nm, "_ld_valid"}, {31'b0, ld_valid}, 32'd0);
    chk({nm, "_stall"}, {31'b0, stall}, 32'd0);
    chk({nm, "_err"}, {30'b0, adel, ades}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r;
    idle_inputs();
    reset = 1;
    repeat (2) @(negedge clk);
    #2;
    chk_reset_outputs("reset");
    reset = 0;

    //       name    ld sz  sg addr          wdata         rd rv rdata         hold be       exp_wd        exp_ld
    access("sw",     0, 2'b10, 0, 32'h100,  32'h12345678, 0, 0, 32'h0,         0, 4'b1111, 32'h12345678, 32'h0);
    access("sb",     0, 2'b00, 0, 32'h103,  32'h000000AB, 3, 0, 32'h0,         0, 4'b1000, 32'hABABABAB, 32'h0);
    access("lb",     1, 2'b00, 1, 32'h102,  32'h0,        0, 2, 32'h80FF7F00,  0, 4'b1111, 32'h0,        32'hFFFFFFFF);
    access("lbu",    1, 2'b00, 0, 32'h102,  32'h0,        0, 0, 32'h80FF7F00,  0, 4'b1111, 32'h0,        32'h000000FF);
    access("lh",     1, 2'b01, 1, 32'h102,  32'h0,        1, 1, 32'h80FF7F00,  0, 4'b1111, 32'h0,        32'hFFFF80FF);
    access("lhu",    1, 2'b01, 0, 32'h100,  32'h0,        0, 0, 32'h80FF7F00,  0, 4'b1111, 32'h0,        32'h00007F00);
    access("sh",     0, 2'b01, 0, 32'h102,  32'h1234ABCD, 1, 0, 32'h0,         0, 4'b1100, 32'hABCDABCD, 32'h0);
    access("sz11",   0, 2'b11, 0, 32'h104,  32'h0BADF00D, 0, 0, 32'h0,         0, 4'b1111, 32'h0BADF00D, 32'h0);
    access("lw_top", 1, 2'b10, 0, 32'h2FFC, 32'h0,        0, 0, 32'hDEADBEEF,  0, 4'b1111, 32'h0,        32'hDEADBEEF);
    access("lw_hold",1, 2'b10, 0, 32'h200,  32'h0,        1, 1, 32'hCAFEF00D,  3, 4'b1111, 32'h0,        32'hCAFEF00D);

    err_access("lw_mis",  1, 2'b10, 32'h101);
    err_access("sh_oor",  0, 2'b01, 32'h3000);
    err_access("lh_mis",  1, 2'b01, 32'h101);
    err_access("sb_oor",  0, 2'b00, 32'hFFFFFFFF);

    // reset while waiting for read data, then a stray rvalid
    r.we = 0; r.addr = 32'h40; r.be = 4'b1111; r.wd = 32'h0;
    exp_q.push_back(r);
    @(negedge clk);
    m_valid = 1; m_load = 1; m_size = 2'b10; m_addr = 32'h40;
    @(negedge clk);
    bus_ready = 1;
    @(negedge clk);
    bus_ready = 0;
    #2;
    chk("wait_r_stall", {31'b0, stall}, 32'd1);
    chk("wait_r_no_req", {31'b0, bus_req}, 32'd0);
    @(negedge clk);
    reset = 1; m_valid = 0; m_load = 0;
    @(negedge clk);
    reset = 0;
    bus_rvalid = 1; bus_rdata = 32'h55555555;
    #2;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    bus_rvalid = 0; bus_rdata = 0;
    #2;
    chk_reset_outputs("stray_rvalid");

    access("lb_after", 1, 2'b00, 1, 32'h101, 32'h0, 0, 0, 32'h00007F00, 0, 4'b1111, 32'h0, 32'h0000007F);

    repeat (3) @(negedge clk);
    chk("req_q_empty", exp_q.size(), 32'd0);
    chk("ld_q_empty", ld_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
